// File: rtl/output_drain_unit.sv
// Drains accelerator results: walks node IDs, reads each word from the output SRAM and
// streams the words to the host in node order through a credit-limited return FIFO.
module output_drain_unit #(
    parameter int FV_W        = 16,
    parameter int FV_PER_WORD = 2,
    parameter int NODE_ID_W   = 6,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          task_complete_i,
    input  logic [NODE_ID_W:0]            num_nodes_i,
    output logic                          rd_req_o,
    output logic [NODE_ID_W-1:0]          rd_node_id_o,
    input  logic                          rd_grant_i,
    input  logic                          rd_valid_i,
    input  logic [FV_PER_WORD*FV_W-1:0]   rd_data_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [FV_PER_WORD*FV_W-1:0]   out_data_o,
    output logic [NODE_ID_W-1:0]          out_node_id_o,
    output logic                          out_last_o,
    output logic                          drain_busy_o,
    output logic                          drain_done_o,
    output logic                          err_unexp_o
);
    localparam int DW = FV_PER_WORD * FV_W;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;
    localparam logic [NODE_ID_W:0] ONE_N   = 1;
    localparam logic [CW-1:0]      ONE_C   = 1;
    localparam logic [CW-1:0]      DEPTH_C = FIFO_DEPTH;
    localparam logic [PW-1:0]      ONE_P   = 1;
    localparam logic [SW-1:0]      ONE_S   = 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                 state_q;
    logic                   busy_q, done_q;
    logic                   tc_prev_q;
    logic [NODE_ID_W:0]     n_q, n_d;
    logic [NODE_ID_W:0]     issue_cnt_q, issue_cnt_d;
    logic [NODE_ID_W:0]     ret_cnt_q, ret_cnt_d;
    logic [CW-1:0]          outstanding_q, outstanding_d;
    logic [CW-1:0]          count_q, count_d;
    logic [CW-1:0]          credit_used;
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [SW-1:0]          stale_q, stale_d, stale_carry, stale_rst;
    logic                   err_q, err_d;
    logic [DW-1:0]          data_mem_q [FIFO_DEPTH];
    logic [NODE_ID_W-1:0]   id_mem_q   [FIFO_DEPTH];

    logic start, grant, push, pop, stale_hit, unexp, head_last;

    // Reads that were in flight when reset hit are tracked as stale so their late
    // returns are silently dropped instead of raising err_unexp.
    assign start       = (state_q == S_IDLE) && task_complete_i && !tc_prev_q;
    assign grant       = rd_req_o && rd_grant_i;
    assign stale_hit   = rd_valid_i && (stale_q != '0);
    assign push        = rd_valid_i && (stale_q == '0) && (outstanding_q != '0);
    assign unexp       = rd_valid_i && (stale_q == '0) && (outstanding_q == '0);
    assign pop         = out_valid_o && out_ready_i;
    assign credit_used = outstanding_q + count_q;
    assign stale_carry = stale_q + {1'b0, outstanding_q};
    assign stale_rst   = (rd_valid_i && (stale_carry != '0)) ? stale_carry - ONE_S : stale_carry;

    assign rd_req_o      = (state_q == S_ISSUE) && (issue_cnt_q < n_q) && (credit_used < DEPTH_C);
    assign rd_node_id_o  = rd_req_o ? issue_cnt_q[NODE_ID_W-1:0] : '0;
    assign out_valid_o   = (count_q != '0);
    assign out_data_o    = out_valid_o ? data_mem_q[rd_ptr_q] : '0;
    assign out_node_id_o = out_valid_o ? id_mem_q[rd_ptr_q] : '0;
    assign head_last     = out_valid_o && ({1'b0, id_mem_q[rd_ptr_q]} == n_q - ONE_N);
    assign out_last_o    = head_last;
    assign drain_busy_o  = busy_q;
    assign drain_done_o  = done_q;
    assign err_unexp_o   = err_q;

    always_comb begin
        n_d           = n_q;
        issue_cnt_d   = issue_cnt_q;
        ret_cnt_d     = ret_cnt_q;
        outstanding_d = outstanding_q;
        count_d       = count_q;
        err_d         = err_q | unexp;
        stale_d       = stale_hit ? stale_q - ONE_S : stale_q;
        if (start) begin
            n_d         = num_nodes_i;
            issue_cnt_d = '0;
            ret_cnt_d   = '0;
        end else begin
            if (grant) issue_cnt_d = issue_cnt_q + ONE_N;
            if (push)  ret_cnt_d   = ret_cnt_q + ONE_N;
        end
        if (grant && !push)      outstanding_d = outstanding_q + ONE_C;
        else if (!grant && push) outstanding_d = outstanding_q - ONE_C;
        if (push && !pop)        count_d = count_q + ONE_C;
        else if (!push && pop)   count_d = count_q - ONE_C;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: if (start) begin
                    if (num_nodes_i == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_ISSUE;
                        busy_q  <= 1'b1;
                    end
                end
                S_ISSUE: if (issue_cnt_q == n_q) state_q <= S_WAIT;
                S_WAIT: if (pop && head_last) begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                S_DONE: if (!task_complete_i) begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tc_prev_q     <= 1'b0;
            n_q           <= '0;
            issue_cnt_q   <= '0;
            ret_cnt_q     <= '0;
            outstanding_q <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            err_q         <= 1'b0;
            stale_q       <= stale_rst;
        end else begin
            tc_prev_q     <= task_complete_i;
            n_q           <= n_d;
            issue_cnt_q   <= issue_cnt_d;
            ret_cnt_q     <= ret_cnt_d;
            outstanding_q <= outstanding_d;
            count_q       <= count_d;
            err_q         <= err_d;
            stale_q       <= stale_d;
            if (push) wr_ptr_q <= wr_ptr_q + ONE_P;
            if (pop)  rd_ptr_q <= rd_ptr_q + ONE_P;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && push) begin
            data_mem_q[wr_ptr_q] <= rd_data_i;
            id_mem_q[wr_ptr_q]   <= ret_cnt_q[NODE_ID_W-1:0];
        end
    end
endmodule

// File: tb/tb_output_drain_unit.sv
// Randomized bench for output_drain_unit: an SRAM responder with random latency and a
// host with random backpressure, checked against an in-order node-sequence reference.
module tb_output_drain_unit;
    localparam int FV_W        = 16;
    localparam int FV_PER_WORD = 2;
    localparam int NODE_ID_W   = 6;
    localparam int FIFO_DEPTH  = 4;
    localparam int DW          = FV_W * FV_PER_WORD;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 taskComplete;
    logic [NODE_ID_W:0]   numNodes;
    logic                 rdReq;
    logic [NODE_ID_W-1:0] rdNodeId;
    logic                 rdGrant;
    logic                 rdValid;
    logic [DW-1:0]        rdData;
    logic                 outValid;
    logic                 outReady;
    logic [DW-1:0]        outData;
    logic [NODE_ID_W-1:0] outNodeId;
    logic                 outLast;
    logic                 drainBusy;
    logic                 drainDone;
    logic                 errUnexp;

    int checkCount = 0;
    int errorCount = 0;
    logic [DW-1:0] sramModel [64];

    always #5 clk = ~clk;

    output_drain_unit #(
        .FV_W(FV_W), .FV_PER_WORD(FV_PER_WORD), .NODE_ID_W(NODE_ID_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_i(clk), .reset_i(reset), .task_complete_i(taskComplete), .num_nodes_i(numNodes),
        .rd_req_o(rdReq), .rd_node_id_o(rdNodeId), .rd_grant_i(rdGrant), .rd_valid_i(rdValid),
        .rd_data_i(rdData), .out_valid_o(outValid), .out_ready_i(outReady), .out_data_o(outData),
        .out_node_id_o(outNodeId), .out_last_o(outLast), .drain_busy_o(drainBusy),
        .drain_done_o(drainDone), .err_unexp_o(errUnexp)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rd_req"}, 64'(rdReq), 64'(0));
        checkOutput({tag, "_rd_node_id"}, 64'(rdNodeId), 64'(0));
        checkOutput({tag, "_out_valid"}, 64'(outValid), 64'(0));
        checkOutput({tag, "_out_data"}, 64'(outData), 64'(0));
        checkOutput({tag, "_out_node_id"}, 64'(outNodeId), 64'(0));
        checkOutput({tag, "_out_last"}, 64'(outLast), 64'(0));
        checkOutput({tag, "_busy"}, 64'(drainBusy), 64'(0));
        checkOutput({tag, "_done"}, 64'(drainDone), 64'(0));
        checkOutput({tag, "_err"}, 64'(errUnexp), 64'(0));
    endtask

    // Expected behaviour: node i is requested as the i-th grant while fewer than
    // FIFO_DEPTH words are granted-but-unpopped, and the host sees nodes 0..n-1 in order.
    task automatic applyStimulus(input int n, input int grantPct, input int grantHold,
                                 input int latMin, input int latMax, input int readyPct,
                                 input int readyHold, input bit reEdge,
                                 output int popFirst, output int popLast, output int grantsAtHold);
        int issued = 0, pushed = 0, popped = 0, cyc = 0, lastRet = 0, t;
        int retTime[$];
        int retNode[$];
        bit g, v, r;
        popFirst = -1; popLast = -1; grantsAtHold = -1;
        for (int i = 0; i < n; i++) sramModel[i] = DW'($urandom);
        numNodes = (NODE_ID_W+1)'(n);
        taskComplete = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (popped < n && cyc < 3000) begin
            checkOutput("rd_req", 64'(rdReq), 64'((issued < n) && (issued - popped < FIFO_DEPTH)));
            if (rdReq) checkOutput("rd_node_id", 64'(rdNodeId), 64'(issued));
            checkOutput("out_valid", 64'(outValid), 64'(pushed > popped));
            checkOutput("drain_busy", 64'(drainBusy), 64'(1));
            checkOutput("fifo_occupancy", 64'(pushed - popped <= FIFO_DEPTH), 64'(1));
            if (outValid) begin
                checkOutput("out_node_id", 64'(outNodeId), 64'(popped));
                checkOutput("out_data", 64'(outData), 64'(sramModel[popped]));
                checkOutput("out_last", 64'(outLast), 64'(popped == n - 1));
            end
            if (cyc == readyHold) grantsAtHold = issued;
            if (rdReq) g = (cyc > grantHold) && (int'($urandom_range(99)) < grantPct);
            else       g = 1'($urandom_range(1));
            if (rdReq && g) begin
                t = cyc + int'($urandom_range(latMax, latMin));
                if (t <= lastRet) t = lastRet + 1;
                lastRet = t;
                retTime.push_back(t);
                retNode.push_back(issued);
                issued++;
            end
            v = (retTime.size() > 0) && (retTime[0] == cyc);
            if (v) begin
                rdData = sramModel[retNode[0]];
                void'(retTime.pop_front());
                void'(retNode.pop_front());
                pushed++;
            end else begin
                rdData = DW'($urandom);
            end
            r = (cyc > readyHold) && (int'($urandom_range(99)) < readyPct);
            if (outValid && r) begin
                if (popFirst < 0) popFirst = cyc;
                popLast = cyc;
                popped++;
            end
            rdGrant = g; rdValid = v; outReady = r;
            taskComplete = !(reEdge && cyc == 3);
            @(negedge clk);
            cyc++;
        end
        checkOutput("drain_completed", 64'(popped), 64'(n));
        rdGrant = 1'b0; rdValid = 1'b0; outReady = 1'b0; taskComplete = 1'b1;
        checkOutput("drain_done", 64'(drainDone), 64'(1));
        checkOutput("busy_after", 64'(drainBusy), 64'(0));
        checkOutput("out_valid_after", 64'(outValid), 64'(0));
        checkOutput("rd_req_after", 64'(rdReq), 64'(0));
        taskComplete = 1'b0;
        @(negedge clk);
        checkOutput("done_cleared", 64'(drainDone), 64'(0));
        @(negedge clk);
    endtask

    initial begin
        int pf, pl, gh;
        reset = 1'b1; taskComplete = 1'b0; numNodes = '0; rdGrant = 1'b0;
        rdValid = 1'b0; rdData = '0; outReady = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] N=4 full rate");
        applyStimulus(4, 100, 0, 1, 1, 100, 0, 1'b0, pf, pl, gh);
        checkOutput("first_pop_latency", 64'(pf), 64'(3));
        checkOutput("pops_consecutive", 64'(pl - pf), 64'(3));

        $display("[TB] N=8 host stalled");
        applyStimulus(8, 100, 0, 1, 1, 100, 12, 1'b0, pf, pl, gh);
        checkOutput("grants_while_stalled", 64'(gh), 64'(FIFO_DEPTH));

        $display("[TB] N=0");
        applyStimulus(0, 100, 0, 1, 1, 100, 0, 1'b0, pf, pl, gh);
        checkOutput("n0_no_pop", 64'(pf), 64'(-1));

        $display("[TB] N=5 grant withheld, random latency, re-edge");
        applyStimulus(5, 100, 3, 1, 3, 100, 0, 1'b1, pf, pl, gh);

        $display("[TB] unexpected return and reset mid-drain");
        rdValid = 1'b1; rdData = DW'($urandom);
        @(negedge clk);
        rdValid = 1'b0;
        checkOutput("err_unexp_set", 64'(errUnexp), 64'(1));
        checkOutput("idle_fifo_empty", 64'(outValid), 64'(0));
        @(negedge clk);
        checkOutput("err_sticky", 64'(errUnexp), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("err_cleared", 64'(errUnexp), 64'(0));
        numNodes = 7'd6; taskComplete = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checkOutput("partial_req", 64'(rdReq), 64'(1));
            checkOutput("partial_id", 64'(rdNodeId), 64'(i));
            rdGrant = 1'b1;
            @(negedge clk);
        end
        rdGrant = 1'b0; reset = 1'b1; taskComplete = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        checkAllZero("mid_reset");
        for (int i = 0; i < 3; i++) begin
            rdValid = 1'b1; rdData = DW'($urandom);
            @(negedge clk);
        end
        rdValid = 1'b0;
        checkOutput("late_return_no_err", 64'(errUnexp), 64'(0));
        checkOutput("late_return_dropped", 64'(outValid), 64'(0));
        rdValid = 1'b1;
        @(negedge clk);
        rdValid = 1'b0;
        checkOutput("extra_return_err", 64'(errUnexp), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(6, 100, 0, 1, 2, 100, 0, 1'b0, pf, pl, gh);

        $display("[TB] N=64 random backpressure");
        applyStimulus(64, 70, 0, 1, 3, 50, 0, 1'b0, pf, pl, gh);

        for (int k = 0; k < 4; k++) begin
            applyStimulus(int'($urandom_range(20, 1)), 60, int'($urandom_range(2)), 1, 4, 60, 0, 1'b0, pf, pl, gh);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
